// File: rtl/op_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// op_dispatch_ctrl
// Command-driven sequencer for the shared execution datapath (fpu_double,
// int_calc, int_bit_manip, int_log) and a small operand register bank.
// One command is accepted at a time. Its operands are read from the bank and
// the operation is issued to the selected unit. The controller then waits for
// the result, masks it to the selected width, writes it back and returns a
// response that carries a sign flag.
//
// Optional build macro: FPU_TIMEOUT_EN
//   defined   -> an FPU wait longer than FPU_TIMEOUT cycles ends with
//                rsp_err=1, rsp_data=0 and no bank write
//   undefined -> the FPU wait is unbounded
//
// Ports:
//   clk, rst                        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_unit, cmd_op, cmd_size      unit select, op code, result width
//   cmd_src_a/b, cmd_dst, cmd_imm   bank indices and store immediate
//   unit_op, unit_opa, unit_opb     operation and operands to the units
//   fpu_start, fpu_ready, fpu_out   FPU launch pulse / result valid / result
//   arith_out, bit_out, logic_out   integer unit results
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_sign, rsp_err     masked result, its sign bit, error flag
// -----------------------------------------------------------------------------
module op_dispatch_ctrl #(
  parameter int DATA_W      = 64,
  parameter int NREGS       = 4,
  parameter int INT_LAT     = 1,
  parameter int FPU_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_unit,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_size,
  input  logic [1:0]        cmd_src_a,
  input  logic [1:0]        cmd_src_b,
  input  logic [1:0]        cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [2:0]        unit_op,
  output logic [DATA_W-1:0] unit_opa,
  output logic [DATA_W-1:0] unit_opb,
  output logic              fpu_start,
  input  logic              fpu_ready,
  input  logic [DATA_W-1:0] fpu_out,
  input  logic [DATA_W-1:0] arith_out,
  input  logic [DATA_W-1:0] bit_out,
  input  logic [DATA_W-1:0] logic_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_sign,
  output logic              rsp_err
);

  localparam logic [2:0] U_FPU   = 3'b000;
  localparam logic [2:0] U_ARITH = 3'b001;
  localparam logic [2:0] U_BIT   = 3'b010;
  localparam logic [2:0] U_LOGIC = 3'b011;
  localparam logic [2:0] U_FETCH = 3'b100;
  localparam logic [2:0] U_STORE = 3'b101;

  // One counter serves both the integer latency and the FPU timeout; it is
  // never narrower than 8 bits.
  localparam int CNT_MAX = (FPU_TIMEOUT > INT_LAT) ? FPU_TIMEOUT : INT_LAT;
  localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 8) ? 8 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_LAT - 1);
`ifdef FPU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] FPU_LAST = CNT_W'(FPU_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Keep only the bits of the selected width; upper bits become zero.
  function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] v,
                                                  input logic [1:0] sz);
    logic [DATA_W-1:0] m;
    case (sz)
      2'b00:   m = {{(DATA_W-16){1'b0}}, v[15:0]};
      2'b01:   m = {{(DATA_W-32){1'b0}}, v[31:0]};
      default: m = v;
    endcase
    return m;
  endfunction

  // Top bit of the selected width.
  function automatic logic size_sign(input logic [DATA_W-1:0] v,
                                     input logic [1:0] sz);
    logic s;
    case (sz)
      2'b00:   s = v[15];
      2'b01:   s = v[31];
      default: s = v[DATA_W-1];
    endcase
    return s;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         unit_r, op_r;
  logic [1:0]         size_r, dst_r;
  logic [DATA_W-1:0]  imm_r, opa_r, opb_r, cap_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic               timeout_r, fpu_start_r, cmd_ready_r;
  logic               rsp_valid_r, rsp_sign_r, rsp_err_r;
  logic [DATA_W-1:0]  rsp_data_r;
  logic [DATA_W-1:0]  bank_r [NREGS];

  logic               accept_s, cap_en_s, timeout_s, wr_en_s, res_err_s;
  logic [DATA_W-1:0]  cap_val_s, int_res_s, res_data_s;

  assign cmd_ready = cmd_ready_r;
  assign unit_op   = op_r;
  assign unit_opa  = opa_r;
  assign unit_opb  = opb_r;
  assign fpu_start = fpu_start_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_sign  = rsp_sign_r;
  assign rsp_err   = rsp_err_r;

  // Select the integer unit result for the latched unit code.
  always_comb begin
    int_res_s = {DATA_W{1'b0}};
    case (unit_r)
      U_ARITH: int_res_s = arith_out;
      U_BIT:   int_res_s = bit_out;
      U_LOGIC: int_res_s = logic_out;
      default: int_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state logic plus accept/capture/timeout strobes.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    cap_en_s  = 1'b0;
    cap_val_s = {DATA_W{1'b0}};
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s = 1'b1;
          state_s  = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Only the four compute units (codes 0xx) need to wait for a result.
        if (unit_r[2] == 1'b0) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_WAIT: begin
        if (unit_r == U_FPU) begin
          if (fpu_ready) begin
            cap_en_s  = 1'b1;
            cap_val_s = fpu_out;
            state_s   = ST_WRITE;
          end
`ifdef FPU_TIMEOUT_EN
          else if (wait_cnt_r == FPU_LAST) begin
            timeout_s = 1'b1;
            state_s   = ST_WRITE;
          end
`endif
          else begin
            state_s = ST_WAIT;
          end
        end else if (wait_cnt_r == INT_LAST) begin
          cap_en_s  = 1'b1;
          cap_val_s = int_res_s;
          state_s   = ST_WRITE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WRITE: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Result, error flag and write enable evaluated during WRITE.
  always_comb begin
    res_data_s = {DATA_W{1'b0}};
    res_err_s  = 1'b0;
    wr_en_s    = 1'b0;
    case (unit_r)
      U_FPU, U_ARITH, U_BIT, U_LOGIC: begin
        if (timeout_r) begin
          res_err_s = 1'b1;
        end else begin
          res_data_s = size_mask(cap_r, size_r);
          wr_en_s    = 1'b1;
        end
      end
      U_FETCH: res_data_s = opa_r;
      U_STORE: begin
        res_data_s = size_mask(imm_r, size_r);
        wr_en_s    = 1'b1;
      end
      default: res_err_s = 1'b1;
    endcase
  end

  // State register; cmd_ready is registered so it rises one cycle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
    end
  end

  // WAIT-cycle counter, cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_ONE;
    end else begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Command and operand latch; held as unit drive until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_r <= 3'b000;
      op_r   <= 3'b000;
      size_r <= 2'b00;
      dst_r  <= 2'b00;
      imm_r  <= {DATA_W{1'b0}};
      opa_r  <= {DATA_W{1'b0}};
      opb_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      unit_r <= cmd_unit;
      op_r   <= cmd_op;
      size_r <= cmd_size;
      dst_r  <= cmd_dst;
      imm_r  <= cmd_imm;
      opa_r  <= size_mask(bank_r[cmd_src_a], cmd_size);
      opb_r  <= size_mask(bank_r[cmd_src_b], cmd_size);
    end
  end

  // One-cycle FPU launch pulse, visible during ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_start_r <= 1'b0;
    end else begin
      fpu_start_r <= accept_s && (cmd_unit == U_FPU);
    end
  end

  // Unit result capture and timeout flag, both cleared on a new command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_r     <= {DATA_W{1'b0}};
      timeout_r <= 1'b0;
    end else if (accept_s) begin
      cap_r     <= {DATA_W{1'b0}};
      timeout_r <= 1'b0;
    end else if (cap_en_s) begin
      cap_r <= cap_val_s;
    end else if (timeout_s) begin
      timeout_r <= 1'b1;
    end
  end

  // Register bank write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == ST_WRITE) && wr_en_s) begin
      bank_r[dst_r] <= res_data_s;
    end
  end

  // Response registers: loaded leaving WRITE, valid dropped on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_sign_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else if (state_r == ST_WRITE) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= res_data_s;
      rsp_sign_r  <= size_sign(res_data_s, size_r);
      rsp_err_r   <= res_err_s;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_op_dispatch_ctrl.sv
// Self-checking bench for op_dispatch_ctrl. A behavioural model (bank array
// plus per-command cycle arithmetic) predicts operands, latency and response.
module tb_op_dispatch_ctrl;
  localparam int INT_LAT     = 2;
  localparam int FPU_TIMEOUT = 20;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_unit, cmd_op;
  logic [1:0]  cmd_size, cmd_src_a, cmd_src_b, cmd_dst;
  logic [63:0] cmd_imm;
  logic [2:0]  unit_op;
  logic [63:0] unit_opa, unit_opb;
  logic        fpu_start, fpu_ready;
  logic [63:0] fpu_out, arith_out, bit_out, logic_out;
  logic        rsp_valid, rsp_ready, rsp_sign, rsp_err;
  logic [63:0] rsp_data;

  int          checks;
  int          failures;
  logic [63:0] model_bank [4];
  logic [63:0] last_data;
  logic        last_sign;
  logic        last_err;

  op_dispatch_ctrl #(
    .DATA_W(64), .NREGS(4), .INT_LAT(INT_LAT), .FPU_TIMEOUT(FPU_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_unit(cmd_unit), .cmd_op(cmd_op), .cmd_size(cmd_size),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .cmd_imm(cmd_imm),
    .unit_op(unit_op), .unit_opa(unit_opa), .unit_opb(unit_opb),
    .fpu_start(fpu_start), .fpu_ready(fpu_ready), .fpu_out(fpu_out),
    .arith_out(arith_out), .bit_out(bit_out), .logic_out(logic_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sign(rsp_sign), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mask(input logic [63:0] v, input logic [1:0] sz);
    if (sz == 2'd0) return v & 64'h0000_0000_0000_FFFF;
    else if (sz == 2'd1) return v & 64'h0000_0000_FFFF_FFFF;
    else return v;
  endfunction

  function automatic logic ref_sign(input logic [63:0] v, input logic [1:0] sz);
    int w;
    w = (sz == 2'd0) ? 16 : ((sz == 2'd1) ? 32 : 64);
    return v[w-1];
  endfunction

  task automatic drive_noise();
    fpu_out   = {$urandom, $urandom};
    arith_out = {$urandom, $urandom};
    bit_out   = {$urandom, $urandom};
    logic_out = {$urandom, $urandom};
  endtask

  task automatic scramble_cmd();
    cmd_unit  = 3'($urandom);
    cmd_op    = 3'($urandom);
    cmd_size  = 2'($urandom);
    cmd_src_a = 2'($urandom);
    cmd_src_b = 2'($urandom);
    cmd_dst   = 2'($urandom);
    cmd_imm   = {$urandom, $urandom};
  endtask

  // Runs one command from an idle negedge to the first idle negedge after the
  // response handshake. res_val is the unit result presented at capture time.
  task automatic run_cmd(input logic [2:0] unit, input logic [2:0] op, input logic [1:0] size,
                         input logic [1:0] a, input logic [1:0] b, input logic [1:0] dst,
                         input logic [63:0] imm, input logic [63:0] res_val,
                         input int fpu_gap, input bit fpu_never, input int hold);
    logic [63:0] exp_a, exp_b, exp_data;
    logic        exp_err, do_wr;
    int          exp_k, k;
    chk_eq("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_unit = unit; cmd_op = op; cmd_size = size;
    cmd_src_a = a; cmd_src_b = b; cmd_dst = dst; cmd_imm = imm;
    exp_a = ref_mask(model_bank[a], size);
    exp_b = ref_mask(model_bank[b], size);
    if (unit == 3'd0) exp_k = fpu_never ? FPU_TIMEOUT + 3 : fpu_gap + 4;
    else if (unit[2] == 1'b0) exp_k = INT_LAT + 3;
    else exp_k = 3;
    @(negedge clk);  // cycle 1 after the accepting edge
    cmd_valid = 1'b0;
    scramble_cmd();
    chk_eq("issue_opa", unit_opa, exp_a);
    chk_eq("issue_opb", unit_opb, exp_b);
    chk_eq("issue_op", {61'd0, unit_op}, {61'd0, op});
    chk_eq("fpu_start", {63'd0, fpu_start}, {63'd0, (unit == 3'd0)});
    chk_eq("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    k = 1;
    while (k < 80) begin
      if (rsp_valid) break;
      if (k == 2) chk_eq("fpu_start_pulse", {63'd0, fpu_start}, 64'd0);
      drive_noise();
      if (k == 1) begin
        fpu_ready = 1'b1;  // must be ignored during ISSUE
      end else if (unit == 3'd0) begin
        if (!fpu_never && k == fpu_gap + 2) begin
          fpu_ready = 1'b1;
          fpu_out   = res_val;
        end else if (k >= exp_k - 1) begin
          fpu_ready = 1'($urandom_range(0, 1));
        end else begin
          fpu_ready = 1'b0;
        end
      end else begin
        fpu_ready = 1'($urandom_range(0, 1));
        if (k == INT_LAT + 1) begin
          if (unit == 3'd1) arith_out = res_val;
          if (unit == 3'd2) bit_out = res_val;
          if (unit == 3'd3) logic_out = res_val;
        end
      end
      @(negedge clk);
      k++;
    end
    fpu_ready = 1'b0;
    chk_eq("latency", 64'(k), 64'(exp_k));
    exp_err = 1'b0; do_wr = 1'b0; exp_data = 64'd0;
    if (unit[2] == 1'b0) begin
      if (unit == 3'd0 && fpu_never) exp_err = 1'b1;
      else begin exp_data = ref_mask(res_val, size); do_wr = 1'b1; end
    end else if (unit == 3'd4) begin
      exp_data = ref_mask(model_bank[a], size);
    end else if (unit == 3'd5) begin
      exp_data = ref_mask(imm, size); do_wr = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    chk_eq("rsp_data", rsp_data, exp_data);
    chk_eq("rsp_sign", {63'd0, rsp_sign}, {63'd0, ref_sign(exp_data, size)});
    chk_eq("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
    last_data = rsp_data; last_sign = rsp_sign; last_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;  // second command waiting under backpressure
      scramble_cmd();
      drive_noise();
      @(negedge clk);
      chk_eq("hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk_eq("hold_data", rsp_data, exp_data);
      chk_eq("hold_err", {63'd0, rsp_err}, {63'd0, exp_err});
      chk_eq("hold_ready", {63'd0, cmd_ready}, 64'd0);
    end
    chk_eq("opa_stable", unit_opa, exp_a);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk_eq("rsp_cleared", {63'd0, rsp_valid}, 64'd0);
    if (do_wr) model_bank[dst] = exp_data;
  endtask

  task automatic mid_reset();
    cmd_valid = 1'b1; cmd_unit = 3'd1; cmd_op = 3'd0; cmd_size = 2'd2;
    cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd1; cmd_imm = 64'd0;
    @(negedge clk);  // ISSUE
    cmd_valid = 1'b0;
    arith_out = 64'h0000_0000_0000_0077;
    @(negedge clk);  // WAIT
    rst = 1'b0;
    #1;
    chk_eq("mr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk_eq("mr_rsp_data", rsp_data, 64'd0);
    chk_eq("mr_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk_eq("mr_opa", unit_opa, 64'd0);
    chk_eq("mr_op", {61'd0, unit_op}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) model_bank[i] = 64'd0;
    @(negedge clk);
    chk_eq("mr_ready_after", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    logic [2:0] u;
    checks = 0; failures = 0;
    for (int i = 0; i < 4; i++) model_bank[i] = 64'd0;
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; fpu_ready = 1'b0;
    scramble_cmd();
    drive_noise();
    repeat (3) @(negedge clk);
    chk_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk_eq("rst_rsp_data", rsp_data, 64'd0);
    chk_eq("rst_opa", unit_opa, 64'd0);
    chk_eq("rst_fpu_start", {63'd0, fpu_start}, 64'd0);
    chk_eq("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // Store with 32-bit size, then fetch at 64-bit size.
    run_cmd(3'd5, 3'd0, 2'd1, 2'd0, 2'd0, 2'd2, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, 1'b0, 0);
    chk_eq("tp_store_data", last_data, 64'h0000_0000_9ABC_DEF0);
    chk_eq("tp_store_sign", {63'd0, last_sign}, 64'd1);
    run_cmd(3'd4, 3'd0, 2'd2, 2'd2, 2'd0, 2'd0, 64'd0, 64'd0, 0, 1'b0, 0);
    chk_eq("tp_fetch_data", last_data, 64'h0000_0000_9ABC_DEF0);
    chk_eq("tp_fetch_err", {63'd0, last_err}, 64'd0);

    // Arithmetic: 5 + 3 into reg3, then read it back.
    run_cmd(3'd5, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 64'd5, 64'd0, 0, 1'b0, 0);
    run_cmd(3'd5, 3'd0, 2'd2, 2'd0, 2'd0, 2'd1, 64'd3, 64'd0, 0, 1'b0, 0);
    run_cmd(3'd1, 3'd0, 2'd0, 2'd0, 2'd1, 2'd3, 64'd0, 64'd8, 0, 1'b0, 5);
    chk_eq("tp_arith_data", last_data, 64'd8);
    run_cmd(3'd4, 3'd0, 2'd2, 2'd3, 2'd0, 2'd0, 64'd0, 64'd0, 0, 1'b0, 0);
    chk_eq("tp_arith_fetch", last_data, 64'd8);

    // FPU: ready ignored in ISSUE, captured after a 10-cycle gap.
    run_cmd(3'd0, 3'd2, 2'd2, 2'd3, 2'd0, 2'd0, 64'd0, 64'h4000_0000_0000_0000, 10, 1'b0, 2);
    chk_eq("tp_fpu_data", last_data, 64'h4000_0000_0000_0000);
    chk_eq("tp_fpu_sign", {63'd0, last_sign}, 64'd0);

    // Illegal unit: error, zero data, bank unchanged (checked by fetch).
    run_cmd(3'd6, 3'd0, 2'd2, 2'd0, 2'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1'b0, 1);
    chk_eq("tp_illegal_err", {63'd0, last_err}, 64'd1);
    run_cmd(3'd4, 3'd0, 2'd2, 2'd3, 2'd0, 2'd0, 64'd0, 64'd0, 0, 1'b0, 0);
    chk_eq("tp_illegal_bank", last_data, 64'd8);

`ifdef FPU_TIMEOUT_EN
    run_cmd(3'd0, 3'd0, 2'd2, 2'd0, 2'd1, 2'd2, 64'd0, 64'hDEAD_BEEF_0000_0001, 0, 1'b1, 0);
    chk_eq("tp_timeout_err", {63'd0, last_err}, 64'd1);
    run_cmd(3'd4, 3'd0, 2'd2, 2'd2, 2'd0, 2'd0, 64'd0, 64'd0, 0, 1'b0, 0);
    chk_eq("tp_timeout_bank", last_data, 64'h0000_0000_9ABC_DEF0);
`endif

    // Randomised mix of all unit codes, sizes, indices and backpressure.
    for (int n = 0; n < 150; n++) begin
      u = 3'($urandom_range(0, 7));
      run_cmd(u, 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 12), 1'b0,
              $urandom_range(0, 5));
    end

    // Reset during WAIT of an arith op to reg1.
    run_cmd(3'd5, 3'd0, 2'd2, 2'd0, 2'd0, 2'd1, 64'h0000_0000_0000_00AA, 64'd0, 0, 1'b0, 0);
    mid_reset();
    run_cmd(3'd4, 3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 64'd0, 64'd0, 0, 1'b0, 0);
    chk_eq("tp_reset_bank1", last_data, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/op_dispatch_ctrl.md
Name: op_dispatch_ctrl

Overview:
Command-driven sequencer for the shared execution datapath: fpu_double, int_calc, int_bit_manip and int_log, plus a 4-entry operand register bank. Accepts one command at a time over a valid/ready handshake and reads operands from the bank. It issues the operation to the selected unit, waits for the result, masks it to the selected width, writes it back, and returns a response with a sign flag. It replaces switch/button sequencing with a bus-driven controller under the top-level wrapper.

Parameters:
DATA_W, 64, operand/result width
NREGS, 4, register bank depth (index width 2)
INT_LAT, 1, cycles from issue to valid result on the integer units (1..15)
FPU_TIMEOUT, 255, max WAIT cycles for fpu_ready (used only with FPU_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_unit  in  3  000 fpu, 001 arith, 010 bitmanip, 011 logic, 100 fetch, 101 store, 11x illegal
cmd_op  in  3  operation code forwarded to the unit
cmd_size  in  2  00 16-bit, 01 32-bit, 1x 64-bit
cmd_src_a  in  2  bank index of operand A
cmd_src_b  in  2  bank index of operand B
cmd_dst  in  2  bank index for write-back
cmd_imm  in  64  value for store
unit_op  out  3  op to execution units
unit_opa  out  64  operand A to units
unit_opb  out  64  operand B to units
fpu_start  out  1  one-cycle FPU launch pulse
fpu_ready  in  1  FPU result valid
fpu_out  in  64  FPU result
arith_out  in  64  int_calc result
bit_out  in  64  int_bit_manip result
logic_out  in  64  int_log result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  64  masked result
rsp_sign  out  1  MSB of result at the selected size
rsp_err  out  1  illegal unit or timeout

Behaviour:
- Reset (rst=0, async): FSM to IDLE. Bank cleared to 0. All outputs 0 except cmd_ready=0. cmd_ready rises in the first IDLE cycle after reset release. Reset mid-operation aborts the command with no write-back.
- Mask: size 00 keeps [15:0], 01 keeps [31:0], 1x keeps [63:0]. Upper bits are zeroed.
- Sign: bit 15/31/63 of the masked value.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch the command and masked bank[src_a]/bank[src_b]; go to ISSUE.
- ISSUE (1 cycle):
  - cmd_ready=0.
  - Drive unit_op/unit_opa/unit_opb; hold them stable until RESP exits.
  - fpu_start=1 only when unit=fpu.
  - fetch/store/illegal go directly to WRITE; all other units go to WAIT.
- WAIT:
  - Integer units: the result is captured after exactly INT_LAT cycles in WAIT.
  - FPU: capture fpu_out in the first WAIT cycle with fpu_ready=1. fpu_ready asserted during ISSUE is ignored.
- WRITE (1 cycle):
  - Compute result:
    - fetch: masked bank[src_a], no write.
    - store: masked cmd_imm, written to bank[dst].
    - compute units: masked captured value, written to bank[dst].
    - illegal: rsp_err=1, result 0, no write.
  - dst==src is allowed; the operands were already latched.
- RESP:
  - rsp_valid=1 with rsp_data/rsp_sign/rsp_err held stable until rsp_ready=1.
  - On that cycle, clear rsp_valid and go to IDLE. The next command can be accepted on the following cycle.
- Throughput: commands presented while cmd_ready=0 are not consumed.
- Latency: integer ops reach rsp_valid INT_LAT+3 cycles after the accepting edge; fetch/store reach it after 3 cycles.

Optional Feature:
FPU_TIMEOUT_EN:
- Defined: an 8-bit+ counter runs in WAIT for FPU commands. If FPU_TIMEOUT cycles elapse without fpu_ready, go to WRITE with rsp_err=1, rsp_data=0, and no bank write. A late fpu_ready is ignored.
- Undefined: the FPU wait is unbounded and rsp_err is set only for illegal units.

Test Plan:
- Reset and store: store imm=0x1234_5678_9ABC_DEF0, size=01, dst=2, then fetch src_a=2 size=1x. Required: rsp_data=0x0000_0000_9ABC_DEF0, rsp_sign=1, rsp_err=0.
- Arith issue: bank0=5, bank1=3, unit=001 op=000 size=00 dst=3. Required: unit_opa=5, unit_opb=3; with arith_out=8, rsp_data=8 at cycle INT_LAT+3; a subsequent fetch of reg3 returns 8.
- FPU handshake: fpu_ready held at 1 during ISSUE then 0 for 10 cycles, then 1 with fpu_out=0x4000_0000_0000_0000, size=1x. Required: single fpu_start pulse; capture only on the later pulse; rsp_data=0x4000…0, rsp_sign=0.
- Backpressure: hold rsp_ready=0 for 5 cycles while a second cmd_valid is held. Required: response stays stable, cmd_ready=0, and the second command is accepted only after the rsp_ready handshake.
- Illegal unit and timeout: unit=110 gives rsp_err=1, rsp_data=0, bank unchanged. With FPU_TIMEOUT_EN and FPU_TIMEOUT=20, an FPU command with no fpu_ready gives rsp_err=1 after 20 WAIT cycles.
- Reset mid-op: assert rst=0 during WAIT of an arith op to dst=1. Required: outputs return to 0 immediately and bank1=0 after release.
